fir_frame_arbiter: RTL and testbench

Frame-granular round-robin arbiter that shares one FIR filter input port between NUM_CH AXI-Stream sample sources. It sits in front of the dfilter datapath and forwards one complete source frame (up to tlast) at a time. Each forwarded beat is tagged with its channel number, so downstream logic can demultiplex the filtered results. A per-frame beat limit guards the shared filter against a source that never asserts tlast.

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_rr_pick.sv | 37 +++
 rtl/fir_frame_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_fir_frame_arbiter.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// fir_pkg: types and helpers shared by the FIR front-end blocks (arbiter,
// picker) and the dfilter datapath.
package fir_pkg;

   // Sample width of the shared FIR input port.
   localparam int FIR_DATA_W = 16;

   // Frame arbiter states: IDLE picks a channel, BUSY forwards its frame.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } fir_state_e;

   // Width of a channel index for n channels, never less than one bit.
   function automatic int ch_width(input int n);
      int w;
      w = (n <= 2) ? 1 : $clog2(n);
      return w;
   endfunction

endpackage

// File: rtl/fir_rr_pick.sv
// fir_rr_pick: combinational rotate-priority picker. Starting at ptr and
// wrapping around, returns the first channel whose request bit is set.
module fir_rr_pick
   import fir_pkg::*;
#(
   parameter int  NUM_CH = 4,
   localparam int CH_W   = ch_width(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   output logic [CH_W-1:0]   gnt_ch,
   output logic              gnt_any
);

   localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

   logic [NUM_CH-1:0] rot_s;
   logic [CH_W-1:0]   first_s;
   logic [CH_W:0]     sum_s;

   // Rotate the requests so that channel ptr lands on bit 0.
   assign rot_s = NUM_CH'({req, req} >> ptr);

   // Lowest set bit of the rotated vector is the distance from ptr.
   always_comb begin
      first_s = {CH_W{1'b0}};
      for (int j = NUM_CH - 1; j >= 0; j--) begin
         first_s = rot_s[j] ? CH_W'(j) : first_s;
      end
   end

   // Undo the rotation: channel = (ptr + distance) mod NUM_CH.
   assign sum_s   = {1'b0, ptr} + {1'b0, first_s};
   assign gnt_ch  = (sum_s >= NUM_CH_V) ? CH_W'(sum_s - NUM_CH_V) : CH_W'(sum_s);
   assign gnt_any = |req;

endmodule

// File: rtl/fir_frame_arbiter.sv
// fir_frame_arbiter: shares one FIR input port between NUM_CH AXI-Stream
// sources, forwarding one whole frame at a time in round-robin order. Each
// beat carries its channel in tdest; a beat limit per grant forces an end of
// frame on a source that never sends tlast and flags it in ovf_err.
module fir_frame_arbiter
   import fir_pkg::*;
#(
   parameter int  NUM_CH    = 4,
   parameter int  DATA_W    = FIR_DATA_W,
   parameter int  MAX_BEATS = 1024,
   localparam int CH_W      = ch_width(NUM_CH)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     err_clr,
   input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
   input  logic [NUM_CH-1:0]        s_axis_tvalid,
   input  logic [NUM_CH-1:0]        s_axis_tlast,
   output logic [NUM_CH-1:0]        s_axis_tready,
   output logic [DATA_W-1:0]        m_axis_tdata,
   output logic                     m_axis_tvalid,
   output logic                     m_axis_tlast,
   output logic [CH_W-1:0]          m_axis_tdest,
   input  logic                     m_axis_tready,
   output logic                     grant_valid,
   output logic [CH_W-1:0]          grant_ch,
   output logic [NUM_CH-1:0]        ovf_err
);

   localparam int                BCNT_W    = $clog2(MAX_BEATS + 1);
   localparam logic [BCNT_W-1:0] BEAT_LAST = BCNT_W'(MAX_BEATS - 1);
   localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

   fir_state_e          state_q, state_d;
   logic [CH_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [CH_W-1:0]     grant_ch_q, grant_ch_d;
   logic [BCNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic                m_valid_q, m_valid_d;
   logic                m_last_q, m_last_d;
   logic [DATA_W-1:0]   m_data_q, m_data_d;
   logic [CH_W-1:0]     m_dest_q, m_dest_d;
   logic [NUM_CH-1:0]   ovf_err_q, ovf_err_d;

   logic [CH_W-1:0]     pick_ch_s;
   logic                pick_any_s;
   logic                sel_valid_s;
   logic                sel_last_s;
   logic [DATA_W-1:0]   sel_data_s;
   logic                src_ready_s;
   logic                accept_s;
   logic                cnt_end_s;
   logic                eof_s;
   logic                forced_s;

   fir_rr_pick #(
      .NUM_CH (NUM_CH)
   ) u_pick (
      .req     (s_axis_tvalid),
      .ptr     (rr_ptr_q),
      .gnt_ch  (pick_ch_s),
      .gnt_any (pick_any_s)
   );

   // Route the granted channel's valid, last and data onto a single lane.
   always_comb begin
      sel_valid_s = 1'b0;
      sel_last_s  = 1'b0;
      sel_data_s  = {DATA_W{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         sel_valid_s = (grant_ch_q == CH_W'(i)) ? s_axis_tvalid[i] : sel_valid_s;
         sel_last_s  = (grant_ch_q == CH_W'(i)) ? s_axis_tlast[i] : sel_last_s;
         sel_data_s  = (grant_ch_q == CH_W'(i)) ? s_axis_tdata[i*DATA_W +: DATA_W] : sel_data_s;
      end
   end

   // Ready depends only on registered state and the FIR's ready, never on tvalid.
   assign src_ready_s = (state_q == BUSY) && (!m_valid_q || m_axis_tready);
   assign accept_s    = src_ready_s && sel_valid_s;
   assign cnt_end_s   = (beat_cnt_q == BEAT_LAST);
   assign eof_s       = accept_s && (sel_last_s || cnt_end_s);
   assign forced_s    = accept_s && cnt_end_s && !sel_last_s;

   // Only the granted channel ever sees ready.
   always_comb begin
      s_axis_tready = {NUM_CH{1'b0}};
      for (int i = 0; i < NUM_CH; i++) begin
         s_axis_tready[i] = src_ready_s && (grant_ch_q == CH_W'(i));
      end
   end

   // Arbitration FSM: grant in IDLE, count beats and end the frame in BUSY.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_ch_d = grant_ch_q;
      beat_cnt_d = beat_cnt_q;
      case (state_q)
         IDLE: begin
            if (enable && pick_any_s) begin
               state_d    = BUSY;
               grant_ch_d = pick_ch_s;
               beat_cnt_d = {BCNT_W{1'b0}};
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            if (eof_s) begin
               state_d    = IDLE;
               beat_cnt_d = beat_cnt_q + BCNT_W'(1);
               rr_ptr_d   = (grant_ch_q == CH_LAST) ? {CH_W{1'b0}} : grant_ch_q + CH_W'(1);
            end else if (accept_s) begin
               beat_cnt_d = beat_cnt_q + BCNT_W'(1);
            end else begin
               state_d = BUSY;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output register: load on acceptance, drain when the FIR takes the beat.
   always_comb begin
      m_valid_d = m_valid_q;
      m_last_d  = m_last_q;
      m_data_d  = m_data_q;
      m_dest_d  = m_dest_q;
      if (accept_s) begin
         m_valid_d = 1'b1;
         m_last_d  = eof_s;
         m_data_d  = sel_data_s;
         m_dest_d  = grant_ch_q;
      end else if (m_axis_tready) begin
         m_valid_d = 1'b0;
         m_last_d  = 1'b0;
      end else begin
         m_valid_d = m_valid_q;
      end
   end

   // Sticky overflow flags; a new overflow wins over a same-cycle clear.
   always_comb begin
      ovf_err_d = err_clr ? {NUM_CH{1'b0}} : ovf_err_q;
      for (int i = 0; i < NUM_CH; i++) begin
         ovf_err_d[i] = ovf_err_d[i] | (forced_s && (grant_ch_q == CH_W'(i)));
      end
   end

   // State, arbitration and output registers; reset drops any partial frame.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         rr_ptr_q   <= {CH_W{1'b0}};
         grant_ch_q <= {CH_W{1'b0}};
         beat_cnt_q <= {BCNT_W{1'b0}};
         m_valid_q  <= 1'b0;
         m_last_q   <= 1'b0;
         m_data_q   <= {DATA_W{1'b0}};
         m_dest_q   <= {CH_W{1'b0}};
         ovf_err_q  <= {NUM_CH{1'b0}};
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         grant_ch_q <= grant_ch_d;
         beat_cnt_q <= beat_cnt_d;
         m_valid_q  <= m_valid_d;
         m_last_q   <= m_last_d;
         m_data_q   <= m_data_d;
         m_dest_q   <= m_dest_d;
         ovf_err_q  <= ovf_err_d;
      end
   end

   assign m_axis_tvalid = m_valid_q;
   assign m_axis_tlast  = m_last_q;
   assign m_axis_tdata  = m_data_q;
   assign m_axis_tdest  = m_dest_q;
   assign grant_valid   = (state_q == BUSY);
   assign grant_ch      = grant_ch_q;
   assign ovf_err       = ovf_err_q;

endmodule

// File: tb/tb_fir_frame_arbiter.sv
// tb_fir_frame_arbiter: directed scenarios for the frame arbiter with
// MAX_BEATS reduced to 8. Sources are fed from per-channel beat tables, and
// every beat the FIR accepts is logged with its cycle number.
module tb_fir_frame_arbiter;

   localparam int NCH = 4;
   localparam int DW  = 16;
   localparam int MB  = 8;
   localparam int CW  = 2;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              enable = 1'b0;
   logic              err_clr = 1'b0;
   logic              m_axis_tready = 1'b1;
   logic [NCH*DW-1:0] s_axis_tdata;
   logic [NCH-1:0]    s_axis_tvalid;
   logic [NCH-1:0]    s_axis_tlast;
   logic [NCH-1:0]    s_axis_tready;
   logic [DW-1:0]     m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tlast;
   logic [CW-1:0]     m_axis_tdest;
   logic              grant_valid;
   logic [CW-1:0]     grant_ch;
   logic [NCH-1:0]    ovf_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // source beat tables: {tlast, data}
   logic [16:0] mem [NCH][64];
   int          head [NCH];
   int          tail [NCH];
   logic [NCH-1:0] fire;

   // accepted output log
   logic [DW-1:0] od [64];
   logic [CW-1:0] ot [64];
   logic          ol [64];
   int            oc [64];
   int            nout = 0;

   logic          pv = 1'b0;
   logic          pr = 1'b0;
   logic [DW-1:0] pd;
   logic [CW-1:0] pt;
   logic          pl;

   fir_frame_arbiter #(
      .NUM_CH    (NCH),
      .DATA_W    (DW),
      .MAX_BEATS (MB)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .enable        (enable),
      .err_clr       (err_clr),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tdest  (m_axis_tdest),
      .m_axis_tready (m_axis_tready),
      .grant_valid   (grant_valid),
      .grant_ch      (grant_ch),
      .ovf_err       (ovf_err)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < NCH; g++) begin : g_src
      assign s_axis_tvalid[g]       = (head[g] < tail[g]);
      assign s_axis_tdata[g*DW +: DW] = mem[g][head[g][5:0]][15:0];
      assign s_axis_tlast[g]        = mem[g][head[g][5:0]][16] & s_axis_tvalid[g];
   end

   // source driver: pop a beat after each handshake
   initial begin
      for (int i = 0; i < NCH; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      fire = '0;
      forever begin
         @(negedge clk);
         fire = s_axis_tvalid & s_axis_tready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NCH; i++) begin
            if (fire[i]) head[i] = head[i] + 1;
         end
      end
   end

   // output monitor: log accepted beats, check ready one-hot and stall hold
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            total++;
            if (!$onehot0(s_axis_tready)) begin
               bad++;
               $display("FAIL tready_onehot: got %b, required one-hot or zero", s_axis_tready);
            end
            if (pv && !pr) begin
               total++;
               if ({m_axis_tvalid, m_axis_tdata, m_axis_tdest, m_axis_tlast} !== {1'b1, pd, pt, pl}) begin
                  bad++;
                  $display("FAIL stall_hold: got v=%b d=%h t=%0d l=%b, required v=1 d=%h t=%0d l=%b",
                           m_axis_tvalid, m_axis_tdata, m_axis_tdest, m_axis_tlast, pd, pt, pl);
               end
            end
            if (m_axis_tvalid && m_axis_tready && nout < 64) begin
               od[nout] = m_axis_tdata;
               ot[nout] = m_axis_tdest;
               ol[nout] = m_axis_tlast;
               oc[nout] = cyc;
               nout = nout + 1;
            end
            pv = m_axis_tvalid;
            pr = m_axis_tready;
            pd = m_axis_tdata;
            pt = m_axis_tdest;
            pl = m_axis_tlast;
         end else begin
            pv = 1'b0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input int ch, input logic [15:0] d, input logic l);
      mem[ch][tail[ch]] = {l, d};
      tail[ch] = tail[ch] + 1;
   endtask

   task automatic clear();
      for (int i = 0; i < NCH; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
      nout = 0;
   endtask

   task automatic wait_outs(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (nout >= n) break;
         step();
      end
      ok = (nout >= n);
   endtask

   task automatic test_reset();
      #1 reset = 1'b0;
      enable = 1'b1;
      m_axis_tready = 1'b1;
      push(0, 16'h0111, 1'b1);
      repeat (3) step();
      total++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tdest} !== 20'h0) begin
         bad++;
         $display("FAIL reset_m_axis: got %h, required 0", {m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tdest});
      end
      total++;
      if (s_axis_tready !== 4'b0000) begin
         bad++;
         $display("FAIL reset_s_ready: got %b, required 0000", s_axis_tready);
      end
      total++;
      if ({grant_valid, grant_ch} !== 3'b000) begin
         bad++;
         $display("FAIL reset_grant: got v=%b ch=%0d, required 0 0", grant_valid, grant_ch);
      end
      total++;
      if (ovf_err !== 4'b0000) begin
         bad++;
         $display("FAIL reset_ovf: got %b, required 0000", ovf_err);
      end
      clear();
      reset = 1'b1;
      repeat (2) step();
      total++;
      if (grant_valid !== 1'b0) begin
         bad++;
         $display("FAIL idle_no_req: grant_valid got %b, required 0", grant_valid);
      end
   endtask

   task automatic test_round_robin();
      bit ok;
      int f, b, ch, fr;
      logic [15:0] ed;
      clear();
      for (int fi = 0; fi < 2; fi++) begin
         for (int c = 0; c < NCH; c++) begin
            for (int bi = 0; bi < 3; bi++) begin
               push(c, 16'(c * 256 + fi * 16 + bi), (bi == 2));
            end
         end
      end
      wait_outs(24, 200, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL rr_count: got %0d beats, required 24", nout);
      end
      for (int k = 0; k < 24; k++) begin
         f  = k / 3;
         b  = k % 3;
         ch = f % NCH;
         fr = f / NCH;
         ed = 16'(ch * 256 + fr * 16 + b);
         total++;
         if ({od[k], ot[k], ol[k]} !== {ed, CW'(ch), (b == 2)}) begin
            bad++;
            $display("FAIL rr_beat%0d: got d=%h t=%0d l=%b, required d=%h t=%0d l=%b",
                     k, od[k], ot[k], ol[k], ed, ch, (b == 2));
         end
         if (k > 0) begin
            total++;
            if (oc[k] - oc[k-1] !== ((b == 0) ? 2 : 1)) begin
               bad++;
               $display("FAIL rr_gap%0d: got %0d cycles, required %0d", k, oc[k] - oc[k-1], (b == 0) ? 2 : 1);
            end
         end
      end
   endtask

   task automatic test_single();
      bit ok;
      int c0;
      repeat (2) step();
      clear();
      c0 = cyc;
      for (int k = 0; k < 5; k++) push(2, 16'(k + 1), (k == 4));
      #1;
      total++;
      if (s_axis_tready !== 4'b0000) begin
         bad++;
         $display("FAIL single_arb_cycle: s_axis_tready got %b, required 0000", s_axis_tready);
      end
      step();
      total++;
      if ({grant_valid, grant_ch, s_axis_tready} !== {1'b1, 2'd2, 4'b0100}) begin
         bad++;
         $display("FAIL single_grant: got v=%b ch=%0d rdy=%b, required v=1 ch=2 rdy=0100",
                  grant_valid, grant_ch, s_axis_tready);
      end
      wait_outs(5, 50, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL single_count: got %0d beats, required 5", nout);
      end
      for (int k = 0; k < 5; k++) begin
         total++;
         if ({od[k], ot[k], ol[k], oc[k]} !== {16'(k + 1), 2'd2, (k == 4), c0 + 2 + k}) begin
            bad++;
            $display("FAIL single_beat%0d: got d=%h t=%0d l=%b cyc=%0d, required d=%h t=2 l=%b cyc=%0d",
                     k, od[k], ot[k], ol[k], oc[k], k + 1, (k == 4), c0 + 2 + k);
         end
      end
   endtask

   task automatic test_stall();
      bit ok;
      repeat (2) step();
      clear();
      for (int k = 0; k < 6; k++) push(1, 16'(16'h0A01 + k), (k == 5));
      wait_outs(2, 50, ok);
      m_axis_tready = 1'b0;
      #1;
      total++;
      if ({m_axis_tvalid, m_axis_tdata, s_axis_tready} !== {1'b1, 16'h0A03, 4'b0000}) begin
         bad++;
         $display("FAIL stall_first: got v=%b d=%h rdy=%b, required v=1 d=0a03 rdy=0000",
                  m_axis_tvalid, m_axis_tdata, s_axis_tready);
      end
      step();
      total++;
      if ({m_axis_tvalid, m_axis_tdata, s_axis_tready} !== {1'b1, 16'h0A03, 4'b0000}) begin
         bad++;
         $display("FAIL stall_second: got v=%b d=%h rdy=%b, required v=1 d=0a03 rdy=0000",
                  m_axis_tvalid, m_axis_tdata, s_axis_tready);
      end
      m_axis_tready = 1'b1;
      wait_outs(6, 50, ok);
      repeat (4) step();
      total++;
      if (nout !== 6) begin
         bad++;
         $display("FAIL stall_count: got %0d beats, required 6", nout);
      end
      for (int k = 0; k < 6; k++) begin
         total++;
         if ({od[k], ot[k], ol[k]} !== {16'(16'h0A01 + k), 2'd1, (k == 5)}) begin
            bad++;
            $display("FAIL stall_beat%0d: got d=%h t=%0d l=%b, required d=%h t=1 l=%b",
                     k, od[k], ot[k], ol[k], 16'h0A01 + k, (k == 5));
         end
      end
   endtask

   task automatic test_overflow();
      bit ok;
      repeat (2) step();
      clear();
      total++;
      if (ovf_err !== 4'b0000) begin
         bad++;
         $display("FAIL ovf_before: got %b, required 0000", ovf_err);
      end
      for (int k = 0; k < 12; k++) push(1, 16'(16'h0B01 + k), (k == 11));
      wait_outs(12, 100, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL ovf_count: got %0d beats, required 12", nout);
      end
      for (int k = 0; k < 12; k++) begin
         total++;
         if ({od[k], ot[k], ol[k]} !== {16'(16'h0B01 + k), 2'd1, (k == 7 || k == 11)}) begin
            bad++;
            $display("FAIL ovf_beat%0d: got d=%h t=%0d l=%b, required d=%h t=1 l=%b",
                     k, od[k], ot[k], ol[k], 16'h0B01 + k, (k == 7 || k == 11));
         end
      end
      total++;
      if (oc[8] - oc[7] !== 2) begin
         bad++;
         $display("FAIL ovf_new_frame_gap: got %0d cycles, required 2", oc[8] - oc[7]);
      end
      step();
      total++;
      if (ovf_err !== 4'b0010) begin
         bad++;
         $display("FAIL ovf_flag: got %b, required 0010", ovf_err);
      end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      total++;
      if (ovf_err !== 4'b0000) begin
         bad++;
         $display("FAIL ovf_clear: got %b, required 0000", ovf_err);
      end
   endtask

   task automatic test_enable();
      bit ok;
      repeat (2) step();
      clear();
      for (int k = 0; k < 4; k++) push(0, 16'(16'h0C01 + k), (k == 3));
      wait_outs(1, 20, ok);
      enable = 1'b0;
      push(3, 16'h0D01, 1'b0);
      push(3, 16'h0D02, 1'b1);
      wait_outs(4, 30, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL en_frame_done: got %0d beats, required 4", nout);
      end
      repeat (6) step();
      total++;
      if ({nout, grant_valid} !== {32'd4, 1'b0}) begin
         bad++;
         $display("FAIL en_blocked: got beats=%0d grant_valid=%b, required 4 0", nout, grant_valid);
      end
      enable = 1'b1;
      #1;
      total++;
      if (grant_valid !== 1'b0) begin
         bad++;
         $display("FAIL en_same_cycle: grant_valid got %b, required 0", grant_valid);
      end
      step();
      total++;
      if ({grant_valid, grant_ch} !== {1'b1, 2'd3}) begin
         bad++;
         $display("FAIL en_regrant: got v=%b ch=%0d, required v=1 ch=3", grant_valid, grant_ch);
      end
      wait_outs(6, 30, ok);
      for (int k = 0; k < 6; k++) begin
         total++;
         if (k < 4) begin
            if ({od[k], ot[k], ol[k]} !== {16'(16'h0C01 + k), 2'd0, (k == 3)}) begin
               bad++;
               $display("FAIL en_beat%0d: got d=%h t=%0d l=%b, required d=%h t=0 l=%b",
                        k, od[k], ot[k], ol[k], 16'h0C01 + k, (k == 3));
            end
         end else begin
            if ({od[k], ot[k], ol[k]} !== {16'(16'h0D01 + k - 4), 2'd3, (k == 5)}) begin
               bad++;
               $display("FAIL en_beat%0d: got d=%h t=%0d l=%b, required d=%h t=3 l=%b",
                        k, od[k], ot[k], ol[k], 16'h0D01 + k - 4, (k == 5));
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [15:0] ed [4];
      logic [1:0]  et [4];
      repeat (2) step();
      clear();
      push(1, 16'h0E01, 1'b0);
      push(1, 16'h0E02, 1'b1);
      wait_outs(2, 30, ok);
      repeat (2) step();
      clear();
      for (int k = 0; k < 5; k++) push(2, 16'(16'h0F01 + k), (k == 4));
      wait_outs(2, 30, ok);
      total++;
      if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 16'h0F03}) begin
         bad++;
         $display("FAIL rst_mid_pre: got v=%b d=%h, required v=1 d=0f03", m_axis_tvalid, m_axis_tdata);
      end
      reset = 1'b0;
      #1;
      total++;
      if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tdest, s_axis_tready, grant_valid, grant_ch}
          !== 27'h0) begin
         bad++;
         $display("FAIL rst_mid_async: got v=%b l=%b d=%h t=%0d rdy=%b gv=%b gch=%0d, required all 0",
                  m_axis_tvalid, m_axis_tlast, m_axis_tdata, m_axis_tdest, s_axis_tready, grant_valid, grant_ch);
      end
      clear();
      push(0, 16'h1001, 1'b0);
      push(0, 16'h1002, 1'b1);
      push(2, 16'h2001, 1'b0);
      push(2, 16'h2002, 1'b1);
      repeat (2) step();
      total++;
      if ({m_axis_tvalid, s_axis_tready, grant_valid} !== 6'b0) begin
         bad++;
         $display("FAIL rst_mid_held: got v=%b rdy=%b gv=%b, required 0", m_axis_tvalid, s_axis_tready, grant_valid);
      end
      reset = 1'b1;
      wait_outs(4, 40, ok);
      ed[0] = 16'h1001; ed[1] = 16'h1002; ed[2] = 16'h2001; ed[3] = 16'h2002;
      et[0] = 2'd0;     et[1] = 2'd0;     et[2] = 2'd2;     et[3] = 2'd2;
      for (int k = 0; k < 4; k++) begin
         total++;
         if ({od[k], ot[k], ol[k]} !== {ed[k], et[k], (k == 1 || k == 3)}) begin
            bad++;
            $display("FAIL rst_after_beat%0d: got d=%h t=%0d l=%b, required d=%h t=%0d l=%b",
                     k, od[k], ot[k], ol[k], ed[k], et[k], (k == 1 || k == 3));
         end
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single();
      test_stall();
      test_overflow();
      test_enable();
      test_reset_mid();
      repeat (3) step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
